// File: rtl/memory_arbiter.sv
// Arbiter that shares one synchronous memory between instruction fetch and load/store.
// It also decodes the memory-mapped LED register and returns read data one cycle after each grant.
module memory_arbiter #(
  parameter logic [31:0] MEMORY_SIZE     = 32'h1000,
  parameter logic [31:0] LED_ADDRESS     = 32'h0000_2000,
  parameter int          MAX_DATA_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  output logic        fetch_ready,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic [31:0] data_address,
  input  logic [31:0] data_wdata,
  input  logic [2:0]  data_write_sections,
  output logic        data_ready,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        mem_enable,
  output logic [31:0] mem_address,
  output logic [2:0]  mem_write_sections,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        led_on
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak;
  logic          data_win;
  logic          fetch_win;
  logic          led_hit;
  logic          in_range;
  logic          read_grant;
  logic [31:0]   sel_address;
  logic [2:0]    sel_sections;

  logic          pend_valid;
  logic          pend_owner;
  logic          pend_from_mem;
  logic [31:0]   pend_value;
  logic [31:0]   response;
  logic [31:0]   fetch_hold;
  logic [31:0]   data_hold;

  // Data normally wins a contested cycle; a saturated streak lets fetch through once.
  always_comb begin
    data_win     = data_req & (~fetch_req | (streak != STREAK_MAX));
    fetch_win    = fetch_req & ~data_win;
    sel_address  = data_win ? data_address : fetch_address;
    sel_sections = data_win ? data_write_sections : 3'b000;
    led_hit      = data_win & (data_address[31:2] == LED_ADDRESS[31:2]);
    in_range     = sel_address < MEMORY_SIZE;
    read_grant   = fetch_win | (data_win & (data_write_sections == 3'b000));

    fetch_ready        = fetch_win;
    data_ready         = data_win;
    mem_enable         = (fetch_win | data_win) & in_range & ~led_hit;
    mem_address        = sel_address;
    mem_write_sections = mem_enable ? sel_sections : 3'b000;
    mem_wdata          = data_win ? data_wdata : 32'h0;
  end

  // Memory reads land straight from mem_rdata; LED and unmapped reads use the captured value.
  always_comb begin
    response     = pend_from_mem ? mem_rdata : pend_value;
    fetch_rvalid = pend_valid & ~pend_owner;
    data_rvalid  = pend_valid & pend_owner;
    fetch_rdata  = fetch_rvalid ? response : fetch_hold;
    data_rdata   = data_rvalid ? response : data_hold;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      streak        <= '0;
      pend_valid    <= 1'b0;
      pend_owner    <= 1'b0;
      pend_from_mem <= 1'b0;
      pend_value    <= 32'h0;
      fetch_hold    <= 32'h0;
      data_hold     <= 32'h0;
      led_on        <= 1'b0;
    end else begin
      if (fetch_win) begin
        streak <= '0;
      end else if (data_win && fetch_req) begin
        if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end else if (data_win) begin
        streak <= '0;
      end

      pend_valid    <= read_grant;
      pend_owner    <= data_win;
      pend_from_mem <= mem_enable;
      pend_value    <= led_hit ? {31'b0, led_on} : 32'h0;

      if (led_hit && (data_write_sections != 3'b000)) led_on <= (data_wdata != 32'h0);

      if (fetch_rvalid) fetch_hold <= response;
      if (data_rvalid)  data_hold  <= response;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized bench for memory_arbiter with a block-RAM model and a
// rule-level reference model of arbitration, address decode and read return.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_address = 32'h0;
  logic        fetch_ready;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        data_req = 1'b0;
  logic [31:0] data_address = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [2:0]  data_write_sections = 3'b000;
  logic        data_ready;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_enable;
  logic [31:0] mem_address;
  logic [2:0]  mem_write_sections;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        led_on;

  int compared = 0;
  int mismatched = 0;

  memory_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_address(fetch_address), .fetch_ready(fetch_ready),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_address(data_address), .data_wdata(data_wdata),
    .data_write_sections(data_write_sections), .data_ready(data_ready),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_enable(mem_enable), .mem_address(mem_address),
    .mem_write_sections(mem_write_sections), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .led_on(led_on)
  );

  always #5 clock = ~clock;

  // Block RAM seen by the DUT, 1024 words, byte-section write enables.
  logic [31:0] ram [0:1023];
  always @(posedge clock) begin
    if (mem_enable) begin
      if (mem_write_sections == 3'b000) begin
        mem_rdata <= ram[mem_address[11:2]];
      end else begin
        if (mem_write_sections[0]) ram[mem_address[11:2]][7:0]   <= mem_wdata[7:0];
        if (mem_write_sections[1]) ram[mem_address[11:2]][15:8]  <= mem_wdata[15:8];
        if (mem_write_sections[2]) ram[mem_address[11:2]][31:16] <= mem_wdata[31:16];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  int          streak_m;
  bit          led_m;
  bit          pend_v;
  bit          pend_own;
  logic [31:0] pend_val;
  logic [31:0] f_hold;
  logic [31:0] d_hold;
  bit          g_f;
  bit          g_d;
  bit          seen_data_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_led(input logic [31:0] a);
    return (a >> 2) == (32'h0000_2000 >> 2);
  endfunction

  task automatic modelReset();
    streak_m = 0;
    led_m    = 0;
    pend_v   = 0;
    pend_own = 0;
    pend_val = 32'h0;
    f_hold   = 32'h0;
    d_hold   = 32'h0;
  endtask

  task automatic checkOutput();
    logic [31:0] addr;
    bit          exp_en;
    logic [2:0]  exp_ws;
    g_d = data_req && (!fetch_req || streak_m < 4);
    g_f = fetch_req && !g_d;
    addr = g_d ? data_address : fetch_address;
    exp_en = (g_f || g_d) && (addr < 32'h1000) && !(g_d && is_led(addr));
    exp_ws = (exp_en && g_d) ? data_write_sections : 3'b000;
    seen_data_ready = data_ready;

    check("fetch_ready", {31'b0, fetch_ready}, {31'b0, g_f});
    check("data_ready", {31'b0, data_ready}, {31'b0, g_d});
    check("mem_enable", {31'b0, mem_enable}, {31'b0, exp_en});
    check("mem_write_sections", {29'b0, mem_write_sections}, {29'b0, exp_ws});
    if (exp_en) check("mem_address", mem_address, addr);
    if (exp_en && exp_ws != 3'b000) check("mem_wdata", mem_wdata, data_wdata);

    check("fetch_rvalid", {31'b0, fetch_rvalid}, {31'b0, pend_v && !pend_own});
    check("data_rvalid", {31'b0, data_rvalid}, {31'b0, pend_v && pend_own});
    check("fetch_rdata", fetch_rdata, (pend_v && !pend_own) ? pend_val : f_hold);
    check("data_rdata", data_rdata, (pend_v && pend_own) ? pend_val : d_hold);
    check("led_on", {31'b0, led_on}, {31'b0, led_m});
  endtask

  task automatic modelUpdate();
    logic [31:0] addr;
    logic [31:0] w;
    addr = g_d ? data_address : fetch_address;

    if (g_f) streak_m = 0;
    else if (g_d && fetch_req) streak_m = (streak_m < 4) ? streak_m + 1 : 4;
    else if (g_d) streak_m = 0;

    if (pend_v) begin
      if (pend_own) d_hold = pend_val;
      else f_hold = pend_val;
    end

    pend_v   = g_f || (g_d && data_write_sections == 3'b000);
    pend_own = g_d;
    if (g_d && is_led(addr)) pend_val = {31'b0, led_m};
    else if (addr < 32'h1000) pend_val = ref_mem[addr[11:2]];
    else pend_val = 32'h0;

    if (g_d && data_write_sections != 3'b000) begin
      if (is_led(addr)) begin
        led_m = (data_wdata != 32'h0);
      end else if (addr < 32'h1000) begin
        w = ref_mem[addr[11:2]];
        if (data_write_sections[0]) w[7:0]   = data_wdata[7:0];
        if (data_write_sections[1]) w[15:8]  = data_wdata[15:8];
        if (data_write_sections[2]) w[31:16] = data_wdata[31:16];
        ref_mem[addr[11:2]] = w;
      end
    end
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance the model at posedge.
  task automatic applyStimulus(input bit f, input logic [31:0] fa, input bit d,
                               input logic [31:0] da, input logic [31:0] wd,
                               input logic [2:0] ws);
    fetch_req = f;
    fetch_address = fa;
    data_req = d;
    data_address = da;
    data_wdata = wd;
    data_write_sections = ws;
    #1;
    checkOutput();
    @(posedge clock);
    modelUpdate();
    @(negedge clock);
  endtask

  function automatic logic [31:0] pick_fetch();
    case ($urandom % 6)
      0:       return 32'h0000_1000;
      1:       return 32'h0000_0FFC;
      default: return {22'b0, 8'($urandom), 2'b00};
    endcase
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom % 8)
      5:       return 32'h0000_2000 | ($urandom % 4);
      6:       return 32'h0000_5000 + {28'b0, 4'($urandom) & 4'hC};
      7:       return ($urandom % 2) ? 32'h0000_0FFC : 32'h0000_1000;
      default: return {24'b0, 6'($urandom), 2'b00};
    endcase
  endfunction

  logic [5:0] order;
  bit          fp;
  bit          dp;
  logic [31:0] rfa;
  logic [31:0] rda;
  logic [31:0] rwd;
  logic [2:0]  rws;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    modelReset();

    // Held in reset: everything reads zero
    repeat (3) @(negedge clock);
    #1;
    checkOutput();
    reset_n = 1'b1;
    @(negedge clock);

    // Single fetch then idle shows the returned word
    applyStimulus(1, 32'h10, 0, 32'h0, 32'h0, 3'b000);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 3'b000);
    check("fetch_deadbeef", fetch_rdata, 32'hDEAD_BEEF);

    // Contested for six cycles: D,D,D,D,F,D
    order = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 32'h14, 1, 32'h20, 32'h0, 3'b000);
      check("grant_order", {31'b0, seen_data_ready}, {31'b0, order[i]});
    end
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 3'b000);

    // LED register on and off
    applyStimulus(0, 32'h0, 1, 32'h2000, 32'h1, 3'b111);
    applyStimulus(0, 32'h0, 1, 32'h2000, 32'h0, 3'b000);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 3'b000);
    check("led_load", data_rdata, 32'h1);
    applyStimulus(0, 32'h0, 1, 32'h2000, 32'h0, 3'b111);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 3'b000);

    // Byte0 store then load back
    applyStimulus(0, 32'h0, 1, 32'h40, 32'h1122_3344, 3'b001);
    applyStimulus(0, 32'h0, 1, 32'h40, 32'h0, 3'b000);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 3'b000);
    check("store_byte0", {24'b0, data_rdata[7:0]}, 32'h44);

    // Out-of-range load returns zero
    applyStimulus(0, 32'h0, 1, 32'h5000, 32'h0, 3'b000);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 3'b000);

    // Reset while a fetch is in flight: the read is discarded
    applyStimulus(0, 32'h0, 1, 32'h2000, 32'h5, 3'b100);
    fetch_req = 1'b1;
    fetch_address = 32'h10;
    data_req = 1'b0;
    data_write_sections = 3'b000;
    #1;
    checkOutput();
    #1;
    reset_n = 1'b0;
    fetch_req = 1'b0;
    modelReset();
    @(posedge clock);
    @(negedge clock);
    #1;
    checkOutput();
    reset_n = 1'b1;
    @(negedge clock);
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 3'b000);

    // Randomized traffic; a loser keeps its request stable until granted
    fp = 0;
    dp = 0;
    rfa = 32'h0;
    rda = 32'h0;
    rwd = 32'h0;
    rws = 3'b000;
    for (int i = 0; i < 400; i++) begin
      if (!fp && ($urandom % 3 != 0)) begin
        fp = 1;
        rfa = pick_fetch();
      end
      if (!dp && ($urandom % 3 != 0)) begin
        dp = 1;
        rda = pick_data();
        rws = ($urandom % 2) ? 3'b000 : 3'($urandom_range(1, 7));
        rwd = ($urandom % 4 == 0) ? 32'h0 : $urandom;
      end
      applyStimulus(fp, rfa, dp, rda, rwd, rws);
      if (g_f) fp = 0;
      if (g_d) dp = 0;
    end
    applyStimulus(0, 32'h0, 0, 32'h0, 32'h0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
